// File: rtl/mem_stage_pkg.sv
// Shared bus layouts, widths and load one-hot bit positions for the memory stage.
// Plays the role of the mycpu.h defines for the SystemVerilog sources.
package mem_stage_pkg;

  localparam int unsigned EX_MEM_LEN = 76;
  localparam int unsigned MEM_WB_LEN = 70;
  localparam int unsigned MEM_RF_LEN = 38;

  // Bit positions inside ld_inst[4:0] = {ld_w, ld_b, ld_h, ld_bu, ld_hu}
  localparam int unsigned LD_W  = 4;
  localparam int unsigned LD_B  = 3;
  localparam int unsigned LD_H  = 2;
  localparam int unsigned LD_BU = 1;
  localparam int unsigned LD_HU = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ld_inst;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } ex_mem_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
  } mem_wb_bus_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_rf_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: selects byte/half by address and extends.
// Halfword selection looks only at addr[1], mirroring the store-side half rule.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_inst,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // An empty one-hot with res_from_mem set falls through to a word load.
  always_comb begin
    data = rdata;
    if (ld_inst[LD_W] || (ld_inst == 5'b0)) begin
      data = rdata;
    end else if (ld_inst[LD_B]) begin
      data = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_inst[LD_BU]) begin
      data = {24'b0, byte_sel};
    end else if (ld_inst[LD_H]) begin
      data = {{16{half_sel[15]}}, half_sel};
    end else if (ld_inst[LD_HU]) begin
      data = {16'b0, half_sel};
    end else begin
      data = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bundle, aligns SRAM load data
// and drives the writeback bundle plus the decode bypass bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned HOLD_EN = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  MEM_allowin,
  input  logic                  EX_MEM_valid,
  input  logic [EX_MEM_LEN-1:0] EX_MEM_bus,
  input  logic                  WB_allowin,
  output logic                  MEM_WB_valid,
  output logic [MEM_WB_LEN-1:0] MEM_WB_bus,
  output logic [MEM_RF_LEN-1:0] MEM_rf_bus,
  input  logic [31:0]           data_sram_rdata
);

  ex_mem_bus_t ex_bus;
  ex_mem_bus_t bus_q;
  logic        mem_valid_q;
  logic        accept;
  logic [31:0] rdata;
  logic [31:0] ld_data;
  logic [31:0] rf_wdata;
  mem_wb_bus_t wb_bus;
  mem_rf_bus_t rf_bus;

  assign ex_bus = ex_mem_bus_t'(EX_MEM_bus);

  // Loads never stall in this stage, so ready_go is constant 1.
  assign MEM_allowin  = ~mem_valid_q | WB_allowin;
  assign accept       = EX_MEM_valid & MEM_allowin;
  assign MEM_WB_valid = mem_valid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
    end else if (MEM_allowin) begin
      mem_valid_q <= EX_MEM_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_q <= '0;
    end else if (accept) begin
      bus_q <= ex_bus;
    end
  end

  generate
    if (HOLD_EN != 0) begin : g_hold
      logic        first_cyc_q;
      logic        hold_vld_q;
      logic [31:0] hold_data_q;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          first_cyc_q <= 1'b0;
        end else begin
          first_cyc_q <= accept;
        end
      end

      // SRAM data is only valid in the first cycle; keep it if writeback stalls then.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          hold_vld_q  <= 1'b0;
          hold_data_q <= 32'b0;
        end else if (accept) begin
          hold_vld_q  <= 1'b0;
        end else if (first_cyc_q && mem_valid_q && !WB_allowin) begin
          hold_vld_q  <= 1'b1;
          hold_data_q <= data_sram_rdata;
        end
      end

      assign rdata = hold_vld_q ? hold_data_q : data_sram_rdata;
    end else begin : g_no_hold
      assign rdata = data_sram_rdata;
    end
  endgenerate

  mem_load_align u_load_align (
    .ld_inst (bus_q.ld_inst),
    .addr    (bus_q.alu_result[1:0]),
    .rdata   (rdata),
    .data    (ld_data)
  );

  always_comb begin
    rf_wdata = bus_q.res_from_mem ? ld_data : bus_q.alu_result;

    wb_bus          = '0;
    wb_bus.rf_we    = bus_q.rf_we & mem_valid_q;
    wb_bus.rf_waddr = bus_q.rf_waddr;
    wb_bus.rf_wdata = rf_wdata;
    wb_bus.pc       = bus_q.pc;

    rf_bus          = '0;
    rf_bus.rf_we    = bus_q.rf_we & mem_valid_q;
    rf_bus.rf_waddr = bus_q.rf_waddr;
    rf_bus.rf_wdata = rf_wdata;
  end

  assign MEM_WB_bus = wb_bus;
  assign MEM_rf_bus = rf_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, stall/reset sequences,
// then randomized traffic checked against a behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        MEM_allowin;
  logic        EX_MEM_valid;
  logic [75:0] EX_MEM_bus;
  logic        WB_allowin;
  logic        MEM_WB_valid;
  logic [69:0] MEM_WB_bus;
  logic [37:0] MEM_rf_bus;
  logic [31:0] data_sram_rdata;

  int n_vec;
  int n_err;

  mem_stage #(.HOLD_EN(1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .MEM_allowin     (MEM_allowin),
    .EX_MEM_valid    (EX_MEM_valid),
    .EX_MEM_bus      (EX_MEM_bus),
    .WB_allowin      (WB_allowin),
    .MEM_WB_valid    (MEM_WB_valid),
    .MEM_WB_bus      (MEM_WB_bus),
    .MEM_rf_bus      (MEM_rf_bus),
    .data_sram_rdata (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ld;
    logic        rfm;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] mk_bus(input logic [31:0] pc, input logic [4:0] ld,
                                         input logic rfm, input logic we,
                                         input logic [4:0] wa, input logic [31:0] alu);
    return {pc, ld, rfm, we, wa, alu};
  endfunction

  // Reference alignment computed arithmetically from the load rules.
  function automatic logic [31:0] ref_align(input logic [4:0] ld, input logic [1:0] a,
                                            input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a)) % 256;
    h = (d >> (16 * (a / 2))) % 65536;
    case (ld)
      5'b01000: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      5'b00010: return b;
      5'b00100: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5'b00001: return h;
      default:  return d;
    endcase
  endfunction

  // Behavioural model state: the instruction in the stage and its first-cycle SRAM data.
  logic        m_valid, m_first, m_rfm, m_we;
  logic [4:0]  m_ld, m_wa;
  logic [31:0] m_alu, m_pc, m_data;

  initial begin
    logic [31:0] exp_wd;
    logic        exp_allow;
    logic        acc;
    logic [4:0]  r_ld;
    n_vec = 0;
    n_err = 0;

    tbl[0] = '{5'b10000, 1'b1, 1'b1, 5'd3,  32'h0000_1000, 32'h1C00_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[1] = '{5'b01000, 1'b1, 1'b1, 5'd4,  32'h0000_1003, 32'h1C00_0004, 32'h80FF_1234, 32'hFFFF_FF80};
    tbl[2] = '{5'b00010, 1'b1, 1'b1, 5'd6,  32'h0000_1003, 32'h1C00_0008, 32'h80FF_1234, 32'h0000_0080};
    tbl[3] = '{5'b00100, 1'b1, 1'b1, 5'd8,  32'h0000_1002, 32'h1C00_000C, 32'h80FF_1234, 32'hFFFF_80FF};
    tbl[4] = '{5'b00001, 1'b1, 1'b1, 5'd9,  32'h0000_1000, 32'h1C00_0010, 32'h80FF_1234, 32'h0000_1234};
    tbl[5] = '{5'b00100, 1'b1, 1'b1, 5'd11, 32'h0000_1003, 32'h1C00_0014, 32'h80FF_1234, 32'hFFFF_80FF};
    tbl[6] = '{5'b01000, 1'b1, 1'b1, 5'd12, 32'h0000_1001, 32'h1C00_0018, 32'h80FF_1234, 32'h0000_0012};
    tbl[7] = '{5'b00000, 1'b0, 1'b1, 5'd5,  32'h0000_0042, 32'h1C00_001C, 32'hCAFE_F00D, 32'h0000_0042};

    resetn          = 1'b0;
    EX_MEM_valid    = 1'b0;
    EX_MEM_bus      = '0;
    WB_allowin      = 1'b1;
    data_sram_rdata = '0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_valid", 70'(MEM_WB_valid), 70'(0));
    chk("reset_allowin", 70'(MEM_allowin), 70'(1));
    chk("reset_wb_bus", MEM_WB_bus, 70'(0));
    chk("reset_rf_bus", 70'(MEM_rf_bus), 70'(0));
    resetn = 1'b1;
    tick();

    // Directed table: accept one instruction, supply SRAM data in its MEM cycle.
    for (int i = 0; i < 8; i++) begin
      EX_MEM_valid = 1'b1;
      EX_MEM_bus   = mk_bus(tbl[i].pc, tbl[i].ld, tbl[i].rfm, tbl[i].we, tbl[i].waddr, tbl[i].alu);
      tick();
      EX_MEM_valid    = 1'b0;
      data_sram_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 70'(MEM_WB_valid), 70'(1));
      chk($sformatf("tbl%0d_wb_bus", i), MEM_WB_bus,
          {tbl[i].we, tbl[i].waddr, tbl[i].exp, tbl[i].pc});
      chk($sformatf("tbl%0d_rf_bus", i), 70'(MEM_rf_bus),
          70'({tbl[i].we, tbl[i].waddr, tbl[i].exp}));
      tick();
    end
    @(negedge clk);
    chk("alu_left_rf_we", 70'(MEM_rf_bus[37]), 70'(0));
    chk("alu_left_valid", 70'(MEM_WB_valid), 70'(0));
    tick();

    // Stall three cycles while SRAM data changes after the first cycle.
    EX_MEM_valid = 1'b1;
    EX_MEM_bus   = mk_bus(32'h1C00_0100, 5'b10000, 1'b1, 1'b1, 5'd7, 32'h0000_2000);
    tick();
    EX_MEM_valid    = 1'b0;
    WB_allowin      = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_wdata", c), 70'(MEM_WB_bus[63:32]), 70'(32'h1111_1111));
      chk($sformatf("stall%0d_allowin", c), 70'(MEM_allowin), 70'(0));
      chk($sformatf("stall%0d_valid", c), 70'(MEM_WB_valid), 70'(1));
      tick();
      data_sram_rdata = 32'h2222_2222;
    end
    WB_allowin = 1'b1;
    @(negedge clk);
    chk("stall_release_bus", MEM_WB_bus, {1'b1, 5'd7, 32'h1111_1111, 32'h1C00_0100});
    chk("stall_release_allowin", 70'(MEM_allowin), 70'(1));
    tick();
    @(negedge clk);
    chk("stall_after_valid", 70'(MEM_WB_valid), 70'(0));

    // Store immediately followed by ld_hu: no bubble.
    EX_MEM_valid = 1'b1;
    EX_MEM_bus   = mk_bus(32'h1C00_0200, 5'b00000, 1'b0, 1'b0, 5'd9, 32'h0000_3000);
    tick();
    EX_MEM_bus      = mk_bus(32'h1C00_0204, 5'b00001, 1'b1, 1'b1, 5'd10, 32'h0000_3002);
    data_sram_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    chk("store_valid", 70'(MEM_WB_valid), 70'(1));
    chk("store_rf_we", 70'(MEM_WB_bus[69]), 70'(0));
    chk("store_pc", 70'(MEM_WB_bus[31:0]), 70'(32'h1C00_0200));
    chk("store_allowin", 70'(MEM_allowin), 70'(1));
    tick();
    EX_MEM_valid    = 1'b0;
    data_sram_rdata = 32'hBEEF_5678;
    @(negedge clk);
    chk("ldhu_after_store", MEM_WB_bus, {1'b1, 5'd10, 32'h0000_BEEF, 32'h1C00_0204});
    tick();

    // Reset while stalled with the hold buffer occupied.
    EX_MEM_valid = 1'b1;
    EX_MEM_bus   = mk_bus(32'h1C00_0300, 5'b10000, 1'b1, 1'b1, 5'd4, 32'h0000_4000);
    tick();
    EX_MEM_valid    = 1'b0;
    WB_allowin      = 1'b0;
    data_sram_rdata = 32'h5555_5555;
    tick();
    data_sram_rdata = 32'h6666_6666;
    @(negedge clk);
    chk("prerst_wdata", 70'(MEM_WB_bus[63:32]), 70'(32'h5555_5555));
    chk("prerst_hold_vld", 70'(dut.g_hold.hold_vld_q), 70'(1));
    resetn = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_stall_valid", 70'(MEM_WB_valid), 70'(0));
    chk("rst_stall_rf_we", 70'(MEM_WB_bus[69]), 70'(0));
    chk("rst_stall_hold_vld", 70'(dut.g_hold.hold_vld_q), 70'(0));
    resetn       = 1'b1;
    WB_allowin   = 1'b1;
    EX_MEM_valid = 1'b1;
    EX_MEM_bus   = mk_bus(32'h1C00_0400, 5'b10000, 1'b1, 1'b1, 5'd4, 32'h0000_4004);
    tick();
    EX_MEM_valid    = 1'b0;
    data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("post_rst_live_rdata", 70'(MEM_WB_bus[63:32]), 70'(32'h7777_7777));
    tick();

    // Randomized traffic against the behavioural model.
    resetn = 1'b0;
    tick();
    resetn  = 1'b1;
    m_valid = 1'b0; m_first = 1'b0; m_rfm = 1'b0; m_we = 1'b0;
    m_ld = '0; m_wa = '0; m_alu = '0; m_pc = '0; m_data = '0;
    for (int i = 0; i < 3000; i++) begin
      resetn       = ($urandom_range(99) != 0);
      EX_MEM_valid = $urandom_range(1);
      r_ld         = ($urandom_range(5) == 5) ? 5'b0 : 5'(1 << $urandom_range(4));
      EX_MEM_bus   = mk_bus($urandom, r_ld, 1'($urandom_range(1)), 1'($urandom_range(1)),
                            5'($urandom_range(31)), $urandom);
      WB_allowin      = ($urandom_range(9) < 7);
      data_sram_rdata = $urandom;

      @(negedge clk);
      exp_allow = !m_valid || WB_allowin;
      exp_wd = m_rfm ? ref_align(m_ld, m_alu[1:0], m_first ? data_sram_rdata : m_data) : m_alu;
      chk("rnd_allowin", 70'(MEM_allowin), 70'(exp_allow));
      chk("rnd_valid", 70'(MEM_WB_valid), 70'(m_valid));
      chk("rnd_wb_we", 70'(MEM_WB_bus[69]), 70'(m_we & m_valid));
      chk("rnd_rf_we", 70'(MEM_rf_bus[37]), 70'(m_we & m_valid));
      if (m_valid) begin
        chk("rnd_wb_bus", MEM_WB_bus, {m_we, m_wa, exp_wd, m_pc});
        chk("rnd_rf_bus", 70'(MEM_rf_bus), 70'({m_we, m_wa, exp_wd}));
      end

      @(posedge clk);
      if (!resetn) begin
        m_valid = 1'b0; m_first = 1'b0; m_rfm = 1'b0; m_we = 1'b0;
        m_ld = '0; m_wa = '0; m_alu = '0; m_pc = '0;
      end else begin
        acc = EX_MEM_valid && exp_allow;
        if (m_first) m_data = data_sram_rdata;
        m_first = acc;
        if (exp_allow) m_valid = EX_MEM_valid;
        if (acc) begin
          {m_pc, m_ld, m_rfm, m_we, m_wa, m_alu} = EX_MEM_bus;
        end
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
